// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared core definitions for the fetch queue: the core datapath
//               width, the canonical NOP encoding, and the fetch-pair bundle
//               carried from fetch to decode.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

  // Core instruction / PC width.
  localparam int CORE_XLEN = 32;

  // addi x0, x0, 0 -- presented on any decode slot that holds no entry.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // One fetched instruction together with its PC.
  typedef struct packed {
    logic                 valid;
    logic [CORE_XLEN-1:0] inst;
    logic [CORE_XLEN-1:0] pc;
  } fetch_pair_t;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_mem
// Description : DEPTH x (2*XLEN) entry storage for the fetch queue. Each entry
//               is {pc, inst}. Two synchronous write ports (tail, tail+1) and
//               two asynchronous read ports (head, head+1). The array has no
//               reset; validity is tracked by the occupancy counter upstream.
// Ports       : clk                 - clock, rising edge
//               we_a/waddr_a/wdata_a - write port A
//               we_b/waddr_b/wdata_b - write port B (wins on equal address)
//               raddr_a/rdata_a     - combinational read port A
//               raddr_b/rdata_b     - combinational read port B
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = CORE_XLEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [AW-1:0]     waddr_a,
  input  logic [2*XLEN-1:0] wdata_a,
  input  logic              we_b,
  input  logic [AW-1:0]     waddr_b,
  input  logic [2*XLEN-1:0] wdata_b,
  input  logic [AW-1:0]     raddr_a,
  output logic [2*XLEN-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [2*XLEN-1:0] rdata_b
);

  localparam int DW = 2 * XLEN;

  logic [DW-1:0] entry_q [DEPTH];
  logic [DW-1:0] entry_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (we_a && (waddr_a == AW'(i))) entry_d[i] = wdata_a;
      if (we_b && (waddr_b == AW'(i))) entry_d[i] = wdata_b;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

  assign rdata_a = entry_q[raddr_a];
  assign rdata_b = entry_q[raddr_b];

endmodule : fetch_queue_mem
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Dual-issue instruction buffer between fetch and the dual
//               decoder. Accepts up to two instruction/PC pairs per cycle,
//               presents the two oldest entries as slot A / slot B, and drops
//               everything on flush.
// Ports       : clk, rst_n           - clock / async active-low reset
//               flush                - redirect, discards all entries
//               in_valid_A/B, in_inst_A/B, in_pc_A/B - fetch pair
//               in_ready             - two free entries available
//               instA/B, pcA/B, validA/B - decode slots (head, head+1)
//               deq_A, deq_B         - decoder consumed slot A / slot B
//               count                - registered occupancy
// Config      : FETCH_QUEUE_BYPASS_EN - when defined, an empty queue forwards
//               the fetch pair combinationally to the decode slots.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = CORE_XLEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid_A,
  input  logic                       in_valid_B,
  input  logic [XLEN-1:0]            in_inst_A,
  input  logic [XLEN-1:0]            in_inst_B,
  input  logic [XLEN-1:0]            in_pc_A,
  input  logic [XLEN-1:0]            in_pc_B,
  output logic                       in_ready,
  output logic [XLEN-1:0]            instA,
  output logic [XLEN-1:0]            instB,
  output logic [XLEN-1:0]            pcA,
  output logic [XLEN-1:0]            pcB,
  output logic                       validA,
  output logic                       validB,
  input  logic                       deq_A,
  input  logic                       deq_B,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INST);

  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [AW-1:0]     head_p1, tail_p1;
  logic [2*XLEN-1:0] rd_a, rd_b;
  logic              stored_va, stored_vb;
  logic              bypass;

  logic              slot_va, slot_vb;
  logic [XLEN-1:0]   slot_inst_a, slot_inst_b, slot_pc_a, slot_pc_b;

  logic [1:0]        push_n, pop_n, keep_n;
  logic              we_a, we_b;
  logic [2*XLEN-1:0] wdata_a, wdata_b;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Status derived purely from registered occupancy; pops in the current
  // cycle are never credited, so there is no path from deq_* to in_ready.
  assign in_ready  = (count_q <= CW'(DEPTH - 2));
  assign stored_va = (count_q != '0);
  assign stored_vb = (count_q >= CW'(2));
  assign count     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && !flush;
`else
  assign bypass = 1'b0;
`endif

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_a    (we_a),
    .waddr_a (tail_q),
    .wdata_a (wdata_a),
    .we_b    (we_b),
    .waddr_b (tail_p1),
    .wdata_b (wdata_b),
    .raddr_a (head_q),
    .rdata_a (rd_a),
    .raddr_b (head_p1),
    .rdata_b (rd_b)
  );

  // Decode slot selection: storage at head/head+1, or the live fetch pair
  // when forwarding from an empty queue.
  always_comb begin
    slot_va     = stored_va;
    slot_vb     = stored_vb;
    slot_inst_a = rd_a[XLEN-1:0];
    slot_pc_a   = rd_a[2*XLEN-1:XLEN];
    slot_inst_b = rd_b[XLEN-1:0];
    slot_pc_b   = rd_b[2*XLEN-1:XLEN];
    if (bypass) begin
      slot_va     = in_valid_A;
      slot_vb     = in_valid_A & in_valid_B;
      slot_inst_a = in_inst_A;
      slot_pc_a   = in_pc_A;
      slot_inst_b = in_inst_B;
      slot_pc_b   = in_pc_B;
    end
  end

  assign validA = slot_va;
  assign validB = slot_vb;
  assign instA  = slot_va ? slot_inst_a : NOP;
  assign pcA    = slot_va ? slot_pc_a   : '0;
  assign instB  = slot_vb ? slot_inst_b : NOP;
  assign pcB    = slot_vb ? slot_pc_b   : '0;

  // Push / pop bookkeeping. keep_n is how many incoming entries actually land
  // in storage: all of them normally, or only those the decoder did not take
  // straight off the bypass path.
  always_comb begin
    push_n = 2'd0;
    if (in_ready && in_valid_A) push_n = in_valid_B ? 2'd2 : 2'd1;

    pop_n  = {1'b0, deq_A & slot_va} + {1'b0, deq_A & deq_B & slot_vb};
    keep_n = bypass ? (push_n - pop_n) : push_n;

    // With one bypassed entry consumed, slot B's data is the first to store.
    wdata_a = (bypass && (pop_n != 2'd0)) ? {in_pc_B, in_inst_B} : {in_pc_A, in_inst_A};
    wdata_b = {in_pc_B, in_inst_B};
    we_a    = !flush && (keep_n != 2'd0);
    we_b    = !flush && (keep_n == 2'd2);

    head_d  = head_q + (bypass ? AW'(0) : AW'(pop_n));
    tail_d  = tail_q + AW'(keep_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue (DEPTH=8,
//               XLEN=32). Inputs change on the falling edge; outputs are
//               checked on the falling edge after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n, flush;
  logic            in_valid_A, in_valid_B, in_ready;
  logic [XLEN-1:0] in_inst_A, in_inst_B, in_pc_A, in_pc_B;
  logic [XLEN-1:0] instA, instB, pcA, pcB;
  logic            validA, validB, deq_A, deq_B;
  logic [3:0]      count;

  int n_vec = 0;
  int n_err = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid_A(in_valid_A), .in_valid_B(in_valid_B),
    .in_inst_A(in_inst_A), .in_inst_B(in_inst_B),
    .in_pc_A(in_pc_A), .in_pc_B(in_pc_B), .in_ready(in_ready),
    .instA(instA), .instB(instB), .pcA(pcA), .pcB(pcB),
    .validA(validA), .validB(validB),
    .deq_A(deq_A), .deq_B(deq_B), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction word the bench associates with a given PC.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A00_0093;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic va, input logic vb, input logic [31:0] pa,
                       input logic [31:0] pb, input logic da, input logic db,
                       input logic fl);
    in_valid_A = va;  in_valid_B = vb;
    in_pc_A = pa;     in_inst_A = inst_of(pa);
    in_pc_B = pb;     in_inst_B = inst_of(pb);
    deq_A = da;       deq_B = db;  flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (count !== 4'd0)    begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_vec++; if (validA !== 1'b0)   begin n_err++; $display("FAIL reset_validA got %b want 0", validA); end
    n_vec++; if (validB !== 1'b0)   begin n_err++; $display("FAIL reset_validB got %b want 0", validB); end
    n_vec++; if (instA !== 32'h13)  begin n_err++; $display("FAIL reset_instA got %h want 00000013", instA); end
    n_vec++; if (instB !== 32'h13)  begin n_err++; $display("FAIL reset_instB got %h want 00000013", instB); end
    n_vec++; if (pcA !== 32'h0)     begin n_err++; $display("FAIL reset_pcA got %h want 0", pcA); end
    n_vec++; if (pcB !== 32'h0)     begin n_err++; $display("FAIL reset_pcB got %h want 0", pcB); end
  endtask

  task automatic test_push_pair();
    do_reset();
    in_valid_A = 1'b1; in_inst_A = 32'h0010_0093; in_pc_A = 32'h0;
    in_valid_B = 1'b1; in_inst_B = 32'h0020_0113; in_pc_B = 32'h4;
`ifndef FETCH_QUEUE_BYPASS_EN
    #1;
    n_vec++; if (validA !== 1'b0) begin n_err++; $display("FAIL push_no_bypass_validA got %b want 0", validA); end
`endif
    cycle();
    idle();
    n_vec++; if (validA !== 1'b1)         begin n_err++; $display("FAIL push_validA got %b want 1", validA); end
    n_vec++; if (validB !== 1'b1)         begin n_err++; $display("FAIL push_validB got %b want 1", validB); end
    n_vec++; if (instA !== 32'h0010_0093) begin n_err++; $display("FAIL push_instA got %h want 00100093", instA); end
    n_vec++; if (pcA !== 32'h0)           begin n_err++; $display("FAIL push_pcA got %h want 0", pcA); end
    n_vec++; if (instB !== 32'h0020_0113) begin n_err++; $display("FAIL push_instB got %h want 00200113", instB); end
    n_vec++; if (pcB !== 32'h4)           begin n_err++; $display("FAIL push_pcB got %h want 4", pcB); end
    n_vec++; if (count !== 4'd2)          begin n_err++; $display("FAIL push_count got %0d want 2", count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'(8 * k), 32'(8 * k + 4), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    idle();
    n_vec++; if (count !== 4'd8)    begin n_err++; $display("FAIL fill_count got %0d want 8", count); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %b want 0", in_ready); end
    drive(1'b1, 1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 1'b0);
    cycle();
    idle();
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL full_drop_count got %0d want 8", count); end
    n_vec++; if (pcA !== 32'h0)  begin n_err++; $display("FAIL full_drop_pcA got %h want 0", pcA); end
    deq_A = 1'b1;
    cycle();
    n_vec++; if (count !== 4'd7)    begin n_err++; $display("FAIL deq1_count got %0d want 7", count); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL deq1_ready got %b want 0", in_ready); end
    n_vec++; if (pcA !== 32'h4)     begin n_err++; $display("FAIL deq1_pcA got %h want 4", pcA); end
    cycle();
    idle();
    n_vec++; if (count !== 4'd6)    begin n_err++; $display("FAIL deq2_count got %0d want 6", count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL deq2_ready got %b want 1", in_ready); end
    n_vec++; if (pcA !== 32'h8)     begin n_err++; $display("FAIL deq2_pcA got %h want 8", pcA); end
    n_vec++; if (pcB !== 32'hC)     begin n_err++; $display("FAIL deq2_pcB got %h want c", pcB); end
  endtask

  task automatic test_wrap();
    logic [31:0] base;
    do_reset();
    drive(1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
    cycle();
    for (int k = 0; k < 20; k++) begin
      base = 32'(8 * k);
      n_vec++; if (pcA !== base) begin n_err++; $display("FAIL wrap_pcA[%0d] got %h want %h", k, pcA, base); end
      n_vec++; if (pcB !== base + 32'h4) begin n_err++; $display("FAIL wrap_pcB[%0d] got %h want %h", k, pcB, base + 32'h4); end
      n_vec++; if (instA !== inst_of(base)) begin n_err++; $display("FAIL wrap_instA[%0d] got %h want %h", k, instA, inst_of(base)); end
      drive(1'b1, 1'b1, base + 32'h8, base + 32'hC, 1'b1, 1'b1, 1'b0);
      cycle();
    end
    idle();
    n_vec++; if (count !== 4'd2) begin n_err++; $display("FAIL wrap_count got %0d want 2", count); end
  endtask

  task automatic test_push2_pop1();
    do_reset();
    drive(1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    n_vec++; if (count !== 4'd3) begin n_err++; $display("FAIL p2p1_pre_count got %0d want 3", count); end
    drive(1'b1, 1'b1, 32'hC, 32'h10, 1'b1, 1'b0, 1'b0);
    cycle();
    idle();
    n_vec++; if (count !== 4'd4) begin n_err++; $display("FAIL p2p1_count got %0d want 4", count); end
    n_vec++; if (pcA !== 32'h4)  begin n_err++; $display("FAIL p2p1_pcA got %h want 4", pcA); end
    n_vec++; if (pcB !== 32'h8)  begin n_err++; $display("FAIL p2p1_pcB got %h want 8", pcB); end
    // deq_B without deq_A pops nothing.
    deq_B = 1'b1;
    cycle();
    idle();
    n_vec++; if (count !== 4'd4) begin n_err++; $display("FAIL deqB_only_count got %0d want 4", count); end
    n_vec++; if (pcA !== 32'h4)  begin n_err++; $display("FAIL deqB_only_pcA got %h want 4", pcA); end
    deq_A = 1'b1; deq_B = 1'b1;
    cycle();
    n_vec++; if (pcA !== 32'hC)  begin n_err++; $display("FAIL drain_pcA got %h want c", pcA); end
    cycle();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", count); end
    // Dequeue of an empty queue is ignored.
    cycle();
    idle();
    n_vec++; if (count !== 4'd0)  begin n_err++; $display("FAIL empty_deq_count got %0d want 0", count); end
    n_vec++; if (validA !== 1'b0) begin n_err++; $display("FAIL empty_deq_validA got %b want 0", validA); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);  cycle();
    drive(1'b1, 1'b1, 32'h8, 32'hC, 1'b0, 1'b0, 1'b0);  cycle();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0); cycle();
    n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL flush_pre_count got %0d want 5", count); end
    drive(1'b1, 1'b1, 32'h40, 32'h44, 1'b1, 1'b0, 1'b1);
    cycle();
    idle();
    n_vec++; if (count !== 4'd0)    begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
    n_vec++; if (validA !== 1'b0)   begin n_err++; $display("FAIL flush_validA got %b want 0", validA); end
    n_vec++; if (instA !== 32'h13)  begin n_err++; $display("FAIL flush_instA got %h want 00000013", instA); end
    n_vec++; if (pcA !== 32'h0)     begin n_err++; $display("FAIL flush_pcA got %h want 0", pcA); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", in_ready); end
    drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    idle();
    n_vec++; if (count !== 4'd1)  begin n_err++; $display("FAIL post_flush_count got %0d want 1", count); end
    n_vec++; if (pcA !== 32'h80)  begin n_err++; $display("FAIL post_flush_pcA got %h want 80", pcA); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b1, 32'h200, 32'h204, 1'b0, 1'b0, 1'b0);
    cycle();
    idle();
    n_vec++; if (count !== 4'd2) begin n_err++; $display("FAIL arst_pre_count got %0d want 2", count); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (count !== 4'd0)  begin n_err++; $display("FAIL arst_count got %0d want 0", count); end
    n_vec++; if (validA !== 1'b0) begin n_err++; $display("FAIL arst_validA got %b want 0", validA); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    drive(1'b1, 1'b1, 32'h300, 32'h304, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++; if (validA !== 1'b1)             begin n_err++; $display("FAIL byp_validA got %b want 1", validA); end
    n_vec++; if (instA !== inst_of(32'h300))  begin n_err++; $display("FAIL byp_instA got %h want %h", instA, inst_of(32'h300)); end
    cycle();
    idle();
    n_vec++; if (count !== 4'd1)              begin n_err++; $display("FAIL byp_count got %0d want 1", count); end
    n_vec++; if (instA !== inst_of(32'h304))  begin n_err++; $display("FAIL byp_next_instA got %h want %h", instA, inst_of(32'h304)); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_push_pair();
    test_fill();
    test_wrap();
    test_push2_pop1();
    test_flush();
    test_async_reset();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_queue
`default_nettype wire
